hir_fu_issuer: RTL and testbench

- Initiator side of the HIR fixed-latency functional-unit interface.
- Accepts operand pairs on a valid/ready request port and drives the unit's in1/in2/tstart.
- Tracks in-flight operations with a LATENCY-deep valid shift register and captures results into a response FIFO with valid/ready.
- Credit-based flow control guarantees no result is ever dropped, because the unit itself cannot stall.

---
 rtl/hir_fu_issuer.sv | 204 ++++++++++++++++++++
 tb/tb_hir_fu_issuer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hir_fu_issuer.sv
`default_nettype none
// ============================================================================
//  Module   : hir_fu_issuer
//  Purpose  : Initiator side of the HIR fixed-latency functional-unit
//             interface. Accepts operand pairs on a valid/ready request
//             port, issues them to a non-stallable unit (fu_in1/fu_in2/
//             fu_tstart) and collects the results in a response FIFO.
//             Each in-flight op reserves a FIFO slot (credit) when it is
//             issued, so a result can never arrive at a full FIFO.
//
//  Ports    : clk, rst (async, active-high)
//             req_valid/req_ready/req_a/req_b  - operand request port
//             fu_in1/fu_in2/fu_tstart          - registered unit drive
//             fu_out                           - unit result
//             rsp_valid/rsp_ready/rsp_data     - response port (FWFT)
//             busy                             - work in flight or queued
//             perf_issued/perf_stalls          - only with HIR_ISSUER_PERF_EN
//
//  Options  : `define HIR_ISSUER_PERF_EN adds the issue and stall counters.
//
//  Revision : 1.0 - initial release
// ============================================================================
module hir_fu_issuer #(
    parameter int WIDTH      = 32,
    parameter int LATENCY    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] fu_in1,
    output logic [WIDTH-1:0] fu_in2,
    output logic             fu_tstart,
    input  logic [WIDTH-1:0] fu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
`ifdef HIR_ISSUER_PERF_EN
    output logic [31:0]      perf_issued,
    output logic [31:0]      perf_stalls,
`endif
    output logic             busy
);

    // Counters must hold the value FIFO_DEPTH itself.
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int SUM_W = CNT_W + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   fu_in1_q, fu_in1_d;
    logic [WIDTH-1:0]   fu_in2_q, fu_in2_d;
    logic               fu_tstart_q, fu_tstart_d;
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [WIDTH-1:0]   mem_d [FIFO_DEPTH];

    logic               w_fire;
    logic               w_capture;
    logic               w_pop;
    logic [SUM_W-1:0]   w_credit_used;

    // Pointer advance with wrap; depth need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // Handshakes. Credit uses registered state only, so a pop in this
    // cycle frees a slot for the next cycle, never the current one.
    // ------------------------------------------------------------------
    always_comb begin
        w_credit_used = {1'b0, outstanding_q} + {1'b0, count_q};
        req_ready     = w_credit_used < SUM_W'(FIFO_DEPTH);
        w_fire        = req_valid & req_ready;
        w_capture     = vld_q[LATENCY-1];
        rsp_valid     = (count_q != '0);
        w_pop         = rsp_valid & rsp_ready;
    end

    // ------------------------------------------------------------------
    // Issue registers: operands hold their last value when idle.
    // ------------------------------------------------------------------
    always_comb begin
        fu_in1_d    = fu_in1_q;
        fu_in2_d    = fu_in2_q;
        fu_tstart_d = w_fire;
        if (w_fire) begin
            fu_in1_d = req_a;
            fu_in2_d = req_b;
        end
    end

    // ------------------------------------------------------------------
    // In-flight tracker: vld[0] follows the registered issue pulse, so an
    // op fired at edge E reaches vld[LATENCY-1] and is captured at
    // edge E+1+LATENCY.
    // ------------------------------------------------------------------
    generate
        if (LATENCY == 1) begin : g_vld_single
            always_comb begin
                vld_d = fu_tstart_q;
            end
        end else begin : g_vld_chain
            always_comb begin
                vld_d = {vld_q[LATENCY-2:0], fu_tstart_q};
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Counters and FIFO. Fire, capture and pop may all happen in the same
    // cycle; counters move by the net delta.
    // ------------------------------------------------------------------
    always_comb begin
        outstanding_d = outstanding_q + CNT_W'(w_fire) - CNT_W'(w_capture);
        count_d       = count_q + CNT_W'(w_capture) - CNT_W'(w_pop);
        wr_ptr_d      = w_capture ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d      = w_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        mem_d         = mem_q;
        if (w_capture) begin
            mem_d[wr_ptr_q] = fu_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fu_in1_q      <= '0;
            fu_in2_q      <= '0;
            fu_tstart_q   <= 1'b0;
            vld_q         <= '0;
            outstanding_q <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            fu_in1_q      <= fu_in1_d;
            fu_in2_q      <= fu_in2_d;
            fu_tstart_q   <= fu_tstart_d;
            vld_q         <= vld_d;
            outstanding_q <= outstanding_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            mem_q         <= mem_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. rsp_data shows the head slot even when empty (stale value).
    // ------------------------------------------------------------------
    always_comb begin
        fu_in1    = fu_in1_q;
        fu_in2    = fu_in2_q;
        fu_tstart = fu_tstart_q;
        rsp_data  = mem_q[rd_ptr_q];
        busy      = (outstanding_q != '0) || (count_q != '0);
    end

`ifdef HIR_ISSUER_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters, free-running and wrapping.
    // ------------------------------------------------------------------
    logic [31:0] perf_issued_q, perf_issued_d;
    logic [31:0] perf_stalls_q, perf_stalls_d;

    always_comb begin
        perf_issued_d = perf_issued_q + 32'(w_fire);
        perf_stalls_d = perf_stalls_q + 32'(req_valid & ~req_ready);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issued_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            perf_issued_q <= perf_issued_d;
            perf_stalls_q <= perf_stalls_d;
        end
    end

    always_comb begin
        perf_issued = perf_issued_q;
        perf_stalls = perf_stalls_q;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hir_fu_issuer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hir_fu_issuer
//  Purpose  : Self-checking bench for hir_fu_issuer. Instance A (LATENCY=1)
//             drives an adder model through a table of per-cycle vectors;
//             instance B (LATENCY=2) drives a multiplier model through
//             streaming, back-pressure and mid-operation reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hir_fu_issuer;

    logic clk;
    logic rst;

    // Instance A: LATENCY=1, adder
    logic        a_req_valid, a_req_ready, a_fu_tstart, a_rsp_valid, a_rsp_ready, a_busy;
    logic [31:0] a_req_a, a_req_b, a_fu_in1, a_fu_in2, a_fu_out, a_rsp_data;
    // Instance B: LATENCY=2, multiplier
    logic        b_req_valid, b_req_ready, b_fu_tstart, b_rsp_valid, b_rsp_ready, b_busy;
    logic [31:0] b_req_a, b_req_b, b_fu_in1, b_fu_in2, b_fu_out, b_rsp_data;
`ifdef HIR_ISSUER_PERF_EN
    logic [31:0] a_perf_issued, a_perf_stalls, b_perf_issued, b_perf_stalls;
`endif

    hir_fu_issuer #(.WIDTH(32), .LATENCY(1), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_a(a_req_a), .req_b(a_req_b),
        .fu_in1(a_fu_in1), .fu_in2(a_fu_in2), .fu_tstart(a_fu_tstart),
        .fu_out(a_fu_out),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data),
`ifdef HIR_ISSUER_PERF_EN
        .perf_issued(a_perf_issued), .perf_stalls(a_perf_stalls),
`endif
        .busy(a_busy)
    );

    hir_fu_issuer #(.WIDTH(32), .LATENCY(2), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_a(b_req_a), .req_b(b_req_b),
        .fu_in1(b_fu_in1), .fu_in2(b_fu_in2), .fu_tstart(b_fu_tstart),
        .fu_out(b_fu_out),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
`ifdef HIR_ISSUER_PERF_EN
        .perf_issued(b_perf_issued), .perf_stalls(b_perf_stalls),
`endif
        .busy(b_busy)
    );

    // Unit models: not reset, so they keep emitting old results after rst.
    logic [31:0] a_pipe = '0;
    logic [31:0] b_pipe0 = '0;
    logic [31:0] b_pipe1 = '0;
    always @(posedge clk) begin
        a_pipe  <= a_fu_in1 + a_fu_in2;
        b_pipe0 <= b_fu_in1 * b_fu_in2;
        b_pipe1 <= b_pipe0;
    end
    assign a_fu_out = a_pipe;
    assign b_fu_out = b_pipe1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Vector table for instance A: inputs applied before an edge,
    // expected outputs observed just after it.
    // ------------------------------------------------------------------
    typedef struct {
        logic        rv;
        logic [31:0] a;
        logic [31:0] b;
        logic        rr;
        logic        e_ready;
        logic        e_tstart;
        logic [31:0] e_in1;
        logic [31:0] e_in2;
        logic        e_rvld;
        logic [31:0] e_data;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input int rv, input int a, input int b, input int rr,
                        input int er, input int et, input int ei1, input int ei2,
                        input int ev, input int ed, input int eb);
        vec_t v;
        v.rv = rv[0]; v.a = a; v.b = b; v.rr = rr[0];
        v.e_ready = er[0]; v.e_tstart = et[0]; v.e_in1 = ei1; v.e_in2 = ei2;
        v.e_rvld = ev[0]; v.e_data = ed; v.e_busy = eb[0];
        vecs.push_back(v);
    endtask

    // ------------------------------------------------------------------
    // Instance B streaming driver with response scoreboard.
    // ------------------------------------------------------------------
    logic [31:0] exp_q[$];

    task automatic run_b(input int n_ops, input int hold, input int max_cyc);
        int   fired = 0;
        int   got   = 0;
        logic fire;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            @(negedge clk);
            b_rsp_ready = (cyc >= hold);
            checks++;
            if (32'(dut_b.outstanding_q) + 32'(dut_b.count_q) > 32'd4) begin
                failures++;
                $display("FAIL credit_invariant: got %0d, required <= 4",
                         32'(dut_b.outstanding_q) + 32'(dut_b.count_q));
            end
            if (hold > 0 && cyc == hold) begin
                chk("stall_fires", 32'(fired), 32'd4);
                chk("stall_req_ready", 32'(b_req_ready), 32'd0);
                chk("stall_rsp_valid", 32'(b_rsp_valid), 32'd1);
            end
            if (b_rsp_valid && b_rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected: got %0d, expected no response", b_rsp_data);
                end else begin
                    chk($sformatf("rsp_data_%0d", got), b_rsp_data, exp_q.pop_front());
                end
                got++;
            end
            b_req_valid = (fired < n_ops);
            b_req_a     = 32'(fired);
            b_req_b     = 32'(fired + 1);
            fire        = b_req_valid && b_req_ready;
            @(posedge clk);
            #1;
            chk("b_tstart", 32'(b_fu_tstart), 32'(fire));
            if (fire) begin
                chk("b_in1", b_fu_in1, 32'(fired));
                chk("b_in2", b_fu_in2, 32'(fired + 1));
                exp_q.push_back(32'(fired * (fired + 1)));
                fired++;
            end
            if (fired == n_ops && got == n_ops) break;
        end
        b_req_valid = 1'b0;
        chk("b_ops_issued", 32'(fired), 32'(n_ops));
        chk("b_rsp_count", 32'(got), 32'(n_ops));
        chk("b_idle_after_run", 32'(b_busy), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        a_req_valid = 0; a_req_a = 0; a_req_b = 0; a_rsp_ready = 0;
        b_req_valid = 0; b_req_a = 0; b_req_b = 0; b_rsp_ready = 0;
        rst = 1'b1;

        //      rv  a  b rr | rdy ts in1 in2 rv data busy
        addv(0,  0,  0, 0,  1, 0,  0,  0, 0,  0, 0);
        addv(1,  3,  4, 0,  1, 1,  3,  4, 0,  0, 1);
        addv(0,  0,  0, 0,  1, 0,  3,  4, 0,  0, 1);
        addv(0,  0,  0, 0,  1, 0,  3,  4, 1,  7, 1);
        addv(0,  0,  0, 1,  1, 0,  3,  4, 0,  0, 0);
        addv(1, 10, 20, 1,  1, 1, 10, 20, 0,  0, 1);
        addv(1,  5,  6, 1,  1, 1,  5,  6, 0,  0, 1);
        addv(0,  0,  0, 0,  1, 0,  5,  6, 1, 30, 1);
        addv(0,  0,  0, 0,  1, 0,  5,  6, 1, 30, 1);
        addv(0,  0,  0, 1,  1, 0,  5,  6, 1, 11, 1);
        addv(0,  0,  0, 1,  1, 0,  5,  6, 0,  0, 0);
        addv(1,  1,  1, 0,  1, 1,  1,  1, 0,  0, 1);
        addv(1,  2,  2, 0,  1, 1,  2,  2, 0,  0, 1);
        addv(1,  3,  3, 0,  1, 1,  3,  3, 1,  2, 1);
        addv(1,  4,  4, 0,  0, 1,  4,  4, 1,  2, 1);
        addv(1,  5,  5, 0,  0, 0,  4,  4, 1,  2, 1);
        addv(1,  5,  5, 0,  0, 0,  4,  4, 1,  2, 1);
        addv(1,  5,  5, 1,  1, 0,  4,  4, 1,  4, 1);   // pop while full: no fire yet
        addv(1,  5,  5, 1,  1, 1,  5,  5, 1,  6, 1);
        addv(0,  0,  0, 1,  1, 0,  5,  5, 1,  8, 1);
        addv(0,  0,  0, 1,  1, 0,  5,  5, 1, 10, 1);
        addv(0,  0,  0, 1,  1, 0,  5,  5, 0,  4, 0);   // empty: stale head

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(a_req_ready), 32'd1);
        chk("rst_tstart", 32'(a_fu_tstart), 32'd0);
        chk("rst_in1", a_fu_in1, 32'd0);
        chk("rst_in2", a_fu_in2, 32'd0);
        chk("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
        chk("rst_rsp_data", a_rsp_data, 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_b_req_ready", 32'(b_req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven run on instance A
        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) @(negedge clk);
            a_req_valid = vecs[i].rv;
            a_req_a     = vecs[i].a;
            a_req_b     = vecs[i].b;
            a_rsp_ready = vecs[i].rr;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_req_ready", i), 32'(a_req_ready), 32'(vecs[i].e_ready));
            chk($sformatf("v%0d_tstart", i), 32'(a_fu_tstart), 32'(vecs[i].e_tstart));
            chk($sformatf("v%0d_in1", i), a_fu_in1, vecs[i].e_in1);
            chk($sformatf("v%0d_in2", i), a_fu_in2, vecs[i].e_in2);
            chk($sformatf("v%0d_rsp_valid", i), 32'(a_rsp_valid), 32'(vecs[i].e_rvld));
            chk($sformatf("v%0d_rsp_data", i), a_rsp_data, vecs[i].e_data);
            chk($sformatf("v%0d_busy", i), 32'(a_busy), 32'(vecs[i].e_busy));
        end
        @(negedge clk);
        a_req_valid = 1'b0;
        a_rsp_ready = 1'b0;

`ifdef HIR_ISSUER_PERF_EN
        chk("perf_issued", a_perf_issued, 32'd8);
        chk("perf_stalls", a_perf_stalls, 32'd3);
`endif

        // Instance B: streaming with rsp_ready=1, 8 products 0,2,6,...,56
        run_b(8, 0, 80);
        // Instance B: back-pressure, 4 fires then stall, then drain and resume
        run_b(6, 10, 80);

        // Reset with two ops in flight on instance B
        @(negedge clk);
        b_rsp_ready = 1'b1;
        b_req_valid = 1'b1; b_req_a = 32'd7; b_req_b = 32'd8;
        @(negedge clk);
        b_req_a = 32'd9; b_req_b = 32'd10;
        @(negedge clk);
        b_req_valid = 1'b0;
        chk("pre_rst_busy", 32'(b_busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_in1", b_fu_in1, 32'd0);
        chk("async_rst_in2", b_fu_in2, 32'd0);
        chk("async_rst_tstart", 32'(b_fu_tstart), 32'd0);
        chk("async_rst_rsp_valid", 32'(b_rsp_valid), 32'd0);
        chk("async_rst_rsp_data", b_rsp_data, 32'd0);
        chk("async_rst_busy", 32'(b_busy), 32'd0);
        chk("async_rst_req_ready", 32'(b_req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post_rst_rsp_valid_%0d", c), 32'(b_rsp_valid), 32'd0);
            chk($sformatf("post_rst_busy_%0d", c), 32'(b_busy), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
